field_upd_arb: RTL and testbench

//  Shares one register field between N hardware updaters and the software write path.
//  - Round-robin arbitration over valid/ready hardware requests, at most one accepted per cycle.
//  - Applies the accepted op (write/set/clear/saturating increment) to the field storage.
//  - Sits between the hardware-facing update logic and the register block readback mux.

---
 rtl/field_arb_pkg.sv | 16 +
 rtl/field_arb_rr.sv | 32 +++
 rtl/field_upd_arb.sv | 163 ++++++++++++++++
 tb/tb_field_upd_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/field_arb_pkg.sv
// Shared types for the field update arbiter: update opcodes and arbiter states.
package field_arb_pkg;

    typedef enum logic [1:0] {
        OP_WR  = 2'd0,
        OP_SET = 2'd1,
        OP_CLR = 2'd2,
        OP_INC = 2'd3
    } op_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/field_arb_rr.sv
// Rotating find-first-set: picks the first asserted request at or above the
// pointer, wrapping from N-1 back to 0.
module field_arb_rr #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Walk the N offsets from the pointer and keep the first hit.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/field_upd_arb.sv
// Shared register field with N round-robin hardware updaters plus a software
// write path that always wins. Optional grant locking is built only when the
// FIELD_ARB_LOCK_EN macro is defined.
//
//   state  | meaning
//   ARB    | round-robin over all valid requesters
//   LOCKED | only the lock owner may be granted (FIELD_ARB_LOCK_EN builds only)
module field_upd_arb
    import field_arb_pkg::*;
#(
    parameter int                   F_WIDTH = 8,
    parameter int                   N_REQ   = 4,
    parameter logic [F_WIDTH-1:0]   RST_VAL = '0,
    localparam int                  IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sw_wr_en,
    input  logic [F_WIDTH-1:0]          sw_wr_data,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [2*N_REQ-1:0]          req_op,
    input  logic [F_WIDTH*N_REQ-1:0]    req_data,
    input  logic [N_REQ-1:0]            req_lock,
    output logic [N_REQ-1:0]            req_ready,
    output logic [F_WIDTH-1:0]          field_value,
    output logic                        hw_modify,
    output logic [IW-1:0]               grant_id,
    output logic                        ovf
);

    logic [IW-1:0]      ptr;
    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [IW-1:0]      ptr_nxt;
    op_e                sel_op;
    logic [F_WIDTH-1:0] sel_data;
    logic [F_WIDTH:0]   inc_sum;
    logic [F_WIDTH-1:0] field_nxt;
    logic               inc_carry;

`ifdef FIELD_ARB_LOCK_EN
    state_e             state;
    logic [IW-1:0]      owner;
    logic [N_REQ-1:0]   owner_mask;

    // One-hot mask of the current lock owner.
    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == owner) owner_mask[i] = 1'b1;
        end
    end

    // While locked only the owner is eligible; software blocks everyone.
    always_comb begin
        elig = req_valid;
        if (state == LOCKED) elig = req_valid & owner_mask;
        if (sw_wr_en) elig = '0;
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;

    // Software write blocks every hardware requester for the cycle.
    always_comb begin
        elig = req_valid;
        if (sw_wr_en) elig = '0;
    end
`endif

    field_arb_rr #(
        .N  (N_REQ),
        .PW (IW)
    ) u_rr (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = gnt;
    assign ptr_nxt   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Select the granted requester's op and operand (one-hot mux).
    always_comb begin
        sel_op   = OP_WR;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_op   = op_e'(req_op[2*i +: 2]);
                sel_data = req_data[F_WIDTH*i +: F_WIDTH];
            end
        end
    end

    assign inc_sum = {1'b0, field_value} + {1'b0, sel_data};

    // Apply the selected op; increment saturates to all-ones on carry-out.
    always_comb begin
        field_nxt = field_value;
        inc_carry = 1'b0;
        case (sel_op)
            OP_WR:   field_nxt = sel_data;
            OP_SET:  field_nxt = field_value | sel_data;
            OP_CLR:  field_nxt = field_value & ~sel_data;
            OP_INC: begin
                inc_carry = inc_sum[F_WIDTH];
                field_nxt = inc_sum[F_WIDTH] ? '1 : inc_sum[F_WIDTH-1:0];
            end
            default: field_nxt = field_value;
        endcase
    end

    // Field storage, status outputs, round-robin pointer and lock state.
    always_ff @(posedge clk) begin
        if (rst) begin
            field_value <= RST_VAL;
            hw_modify   <= 1'b0;
            grant_id    <= '0;
            ovf         <= 1'b0;
            ptr         <= '0;
`ifdef FIELD_ARB_LOCK_EN
            state       <= ARB;
            owner       <= '0;
`endif
        end else begin
            hw_modify <= 1'b0;
            if (sw_wr_en) begin
                field_value <= sw_wr_data;
                ovf         <= 1'b0;
            end else if (gnt_any) begin
                field_value <= field_nxt;
                hw_modify   <= 1'b1;
                grant_id    <= gnt_idx;
                ptr         <= ptr_nxt;
                if (inc_carry) ovf <= 1'b1;
            end
`ifdef FIELD_ARB_LOCK_EN
            case (state)
                ARB: begin
                    if (gnt_any && req_lock[gnt_idx]) begin
                        state <= LOCKED;
                        owner <= gnt_idx;
                    end
                end
                LOCKED: begin
                    // A stalled owner keeps the lock until it lets go of req_lock.
                    if (gnt_any) begin
                        if (!req_lock[owner]) state <= ARB;
                    end else if (!req_valid[owner] && !req_lock[owner]) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_field_upd_arb.sv
// Directed bench for field_upd_arb (F_WIDTH=8, N_REQ=4, RST_VAL=8'h5A).
module tb_field_upd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_wr_en;
    logic [7:0]  sw_wr_data;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [7:0]  field_value;
    logic        hw_modify;
    logic [1:0]  grant_id;
    logic        ovf;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    field_upd_arb #(
        .F_WIDTH (8),
        .N_REQ   (4),
        .RST_VAL (8'h5A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_wr_en    (sw_wr_en),
        .sw_wr_data  (sw_wr_data),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .field_value (field_value),
        .hw_modify   (hw_modify),
        .grant_id    (grant_id),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = '0;
        req_lock   = '0;
        sw_wr_en   = 1'b0;
        sw_wr_data = '0;
    endtask

    task automatic put(input int i, input logic [1:0] op, input logic [7:0] d, input logic lk);
        req_valid[i]     = 1'b1;
        req_op[2*i +: 2] = op;
        req_data[8*i +: 8] = d;
        req_lock[i]      = lk;
    endtask

    task automatic sw(input logic [7:0] d);
        sw_wr_en   = 1'b1;
        sw_wr_data = d;
    endtask

    // Check outputs registered by the last edge.
    task automatic post(input string tag, input logic [7:0] f, input logic hw,
                        input logic [1:0] g, input logic o);
        chk({tag, "_field"}, 32'(field_value), 32'(f));
        chk({tag, "_hw"},    32'(hw_modify),   32'(hw));
        chk({tag, "_gid"},   32'(grant_id),    32'(g));
        chk({tag, "_ovf"},   32'(ovf),         32'(o));
    endtask

    initial begin
        rst = 1'b1;
        req_op = '0;
        req_data = '0;
        idle();
        tick();
        tick();
        // 1. reset values
        post("rst", 8'h5A, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        #1 chk("rst_ready", 32'(req_ready), 32'h0);

        // 2. all four valid with OP_SET 1<<i; grants rotate 0..3
        for (int i = 0; i < 4; i++) put(i, 2'd1, 8'(1 << i), 1'b0);
        #1 chk("rr0_ready", 32'(req_ready), 32'b0001);
        tick(); post("rr0", 8'h5B, 1'b1, 2'd0, 1'b0);
        #1 chk("rr1_ready", 32'(req_ready), 32'b0010);
        tick(); post("rr1", 8'h5B, 1'b1, 2'd1, 1'b0);
        #1 chk("rr2_ready", 32'(req_ready), 32'b0100);
        tick(); post("rr2", 8'h5F, 1'b1, 2'd2, 1'b0);
        #1 chk("rr3_ready", 32'(req_ready), 32'b1000);
        tick(); post("rr3", 8'h5F, 1'b1, 2'd3, 1'b0);

        // idle cycle holds everything, hw_modify drops
        idle();
        tick(); post("idle", 8'h5F, 1'b0, 2'd3, 1'b0);

        // 3. software write beats requester 2
        sw(8'h00);
        put(2, 2'd0, 8'hFF, 1'b0);
        #1 chk("sw_ready", 32'(req_ready), 32'h0);
        tick(); post("sw", 8'h00, 1'b0, 2'd3, 1'b0);
        sw_wr_en = 1'b0;
        #1 chk("sw_after_ready", 32'(req_ready), 32'b0100);
        tick(); post("sw_after", 8'hFF, 1'b1, 2'd2, 1'b0);
        idle();

        // 4. saturating increment sets ovf, sw write clears it (pointer now 3)
        sw(8'hF0);
        tick();
        idle();
        put(1, 2'd3, 8'h20, 1'b0);
        #1 chk("inc_ready", 32'(req_ready), 32'b0010);
        tick(); post("inc_sat", 8'hFF, 1'b1, 2'd1, 1'b1);
        idle();
        sw(8'h01);
        tick(); post("sw_clr_ovf", 8'h01, 1'b0, 2'd1, 1'b0);
        idle();
        // non-saturating increment (pointer 2 -> finds 0)
        put(0, 2'd3, 8'h05, 1'b0);
        tick(); post("inc", 8'h06, 1'b1, 2'd0, 1'b0);
        idle();
        // clear (pointer 1 -> finds 3)
        put(3, 2'd2, 8'h02, 1'b0);
        tick(); post("clr", 8'h04, 1'b1, 2'd3, 1'b0);
        idle();
        // increment landing exactly on all-ones: no ovf (pointer 0 -> finds 2)
        put(2, 2'd3, 8'hFB, 1'b0);
        tick(); post("inc_edge", 8'hFF, 1'b1, 2'd2, 1'b0);
        idle();

        // 5. pointer at 3, only 0 and 3 valid: grant 3 then 0, pointer ends at 1
        put(0, 2'd0, 8'h11, 1'b0);
        put(3, 2'd0, 8'h33, 1'b0);
        #1 chk("wrap3_ready", 32'(req_ready), 32'b1000);
        tick(); post("wrap3", 8'h33, 1'b1, 2'd3, 1'b0);
        #1 chk("wrap0_ready", 32'(req_ready), 32'b0001);
        tick(); post("wrap0", 8'h11, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) put(i, 2'd0, 8'h20 + 8'(i), 1'b0);
        #1 chk("ptr1_ready", 32'(req_ready), 32'b0010);
        tick(); post("ptr1", 8'h21, 1'b1, 2'd1, 1'b0);
        idle();
        // pointer now 2

`ifdef FIELD_ARB_LOCK_EN
        // 6. requester 1 takes the lock; requester 0 starves
        put(1, 2'd0, 8'h41, 1'b1);
        #1 chk("lk_take_ready", 32'(req_ready), 32'b0010);
        tick(); post("lk_take", 8'h41, 1'b1, 2'd1, 1'b0);
        put(0, 2'd0, 8'h40, 1'b0);
        put(1, 2'd0, 8'h42, 1'b1);
        #1 chk("lk_hold_ready", 32'(req_ready), 32'b0010);
        tick(); post("lk_hold", 8'h42, 1'b1, 2'd1, 1'b0);
        req_valid[1] = 1'b0;
        #1 chk("lk_idle_ready", 32'(req_ready), 32'b0000);
        tick(); post("lk_idle", 8'h42, 1'b0, 2'd1, 1'b0);
        sw(8'h55);
        req_valid[1] = 1'b1;
        #1 chk("lk_sw_ready", 32'(req_ready), 32'b0000);
        tick(); post("lk_sw", 8'h55, 1'b0, 2'd1, 1'b0);
        sw_wr_en = 1'b0;
        put(1, 2'd0, 8'h43, 1'b1);
        #1 chk("lk_after_sw_ready", 32'(req_ready), 32'b0010);
        tick(); post("lk_after_sw", 8'h43, 1'b1, 2'd1, 1'b0);
        put(1, 2'd0, 8'h44, 1'b0);
        #1 chk("lk_rel_ready", 32'(req_ready), 32'b0010);
        tick(); post("lk_rel", 8'h44, 1'b1, 2'd1, 1'b0);
        // back in ARB with pointer 2: requester 0 finally wins
        req_valid[1] = 1'b0;
        #1 chk("lk_arb_ready", 32'(req_ready), 32'b0001);
        tick(); post("lk_arb", 8'h40, 1'b1, 2'd0, 1'b0);
        idle();
        // lock again, then reset mid-lock
        put(1, 2'd0, 8'h46, 1'b1);
        tick(); post("lk_again", 8'h46, 1'b1, 2'd1, 1'b0);
        idle();
        rst = 1'b1;
        tick(); post("lk_rst", 8'h5A, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) put(i, 2'd0, 8'h60 + 8'(i), 1'b0);
        #1 chk("lk_rst_ready", 32'(req_ready), 32'b0001);
        tick(); post("lk_rst_gnt", 8'h60, 1'b1, 2'd0, 1'b0);
        idle();
`else
        // 6. without locking, req_lock is ignored
        put(1, 2'd0, 8'h41, 1'b1);
        #1 chk("nolk_take_ready", 32'(req_ready), 32'b0010);
        tick(); post("nolk_take", 8'h41, 1'b1, 2'd1, 1'b0);
        put(0, 2'd0, 8'h40, 1'b0);
        put(1, 2'd0, 8'h42, 1'b1);
        #1 chk("nolk_rr_ready", 32'(req_ready), 32'b0001);
        tick(); post("nolk_rr", 8'h40, 1'b1, 2'd0, 1'b0);
        // reset mid-operation returns pointer to 0
        rst = 1'b1;
        tick(); post("nolk_rst", 8'h5A, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        idle();
        put(1, 2'd0, 8'h61, 1'b0);
        put(2, 2'd0, 8'h62, 1'b0);
        #1 chk("nolk_rst_ready", 32'(req_ready), 32'b0010);
        tick(); post("nolk_rst_gnt", 8'h61, 1'b1, 2'd1, 1'b0);
        idle();
`endif

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
